bsync_align_sequencer: RTL and testbench
========================================

// Module: bsync_align_sequencer
// PURPOSE
//  Sequences one BSYNC generator instance through reset, capture, calibration and alignment check.
//  Drives the generator's rstn, direction and disable_internal_bsync inputs, and watches its status.
//  Retries on timeout or misalignment, up to a bounded count.
//  Sits between the AXI register bank (start/abort/status) and the BSYNC generator.
// PARAMETERS
//  TIMEOUT_W     20  width of the per-state timeout counter and of timeout_cycles
//  SETTLE_CYCLES 16  cycles gen_rstn is held low in RESET_GEN (>=1)
//  VERIFY_CYCLES 256 cycles gen_align_err must stay low before LOCKED (>=1)
//  MAX_RETRIES   3   retries allowed after the first attempt (0..15)
// PORTS
//  clk               in   1         clock
//  rstn              in   1         synchronous reset, active-low
//  start             in   1         1-cycle pulse: begin/restart sequence
//  abort             in   1         1-cycle pulse: stop, return to IDLE
//  timeout_cycles    in   TIMEOUT_W max cycles in ARM or CALIB; 0 = no timeout
//  gen_rstn          out  1         generator reset (active-low)
//  gen_direction     out  1         generator direction (1 = capture enabled)
//  gen_disable_bsync out  1         generator disable_internal_bsync
//  gen_captured      in   1         generator bsync_captured
//  gen_ready         in   1         generator bsync_ready
//  gen_align_err     in   1         generator bsync_alignment_error
//  gen_delay         in   5         generator bsync_delay (low 5 bits)
//  gen_ratio         in   16        generator bsync_ratio
//  busy              out  1         1 in RESET_GEN/ARM/CALIB/VERIFY
//  locked            out  1         1 in LOCKED
//  fail              out  1         1 in FAIL
//  fail_code         out  2         0 none, 1 ARM timeout, 2 CALIB timeout, 3 lock lost
//  retry_count       out  4         retries consumed in the current run
//  delay_out         out  5         gen_delay latched on entry to LOCKED
//  ratio_out         out  16        gen_ratio latched on entry to LOCKED
// BEHAVIOUR
//  Reset (rstn=0):
//  - State IDLE. gen_rstn=0, gen_direction=0, gen_disable_bsync=1.
//  - busy, locked, fail, fail_code, retry_count, delay_out, ratio_out all 0. Counters cleared.
//  States:
//  - IDLE: gen_rstn=0. start -> RESET_GEN, retry_count:=0, fail_code:=0.
//  - RESET_GEN: gen_rstn=0, direction=0, disable=1 for exactly SETTLE_CYCLES, then -> ARM.
//  - ARM: gen_rstn=1, direction=1. gen_captured -> CALIB.
//    Timeout -> retry path with code 1.
//  - CALIB: gen_ready -> VERIFY, with the verify counter cleared. Timeout -> retry path with code 2.
//  - VERIFY: gen_disable_bsync=0.
//    gen_align_err=1 -> retry path with code 3.
//    VERIFY_CYCLES consecutive cycles without error -> LOCKED; delay_out/ratio_out latched that edge.
//  - LOCKED: outputs as in VERIFY. gen_align_err=1 -> FAIL with code 3 (no retry). start -> restart.
//  - FAIL: gen_rstn=0, direction=0, disable=1. start -> restart. fail_code holds its value.
//  Retry path:
//  - If retry_count < MAX_RETRIES: retry_count+1, fail_code:=code, -> RESET_GEN.
//  - Otherwise: fail_code:=code, -> FAIL.
//  Timeout:
//  - Counter clears on every state entry and increments each cycle in ARM/CALIB.
//  - Timeout fires on the cycle the counter == timeout_cycles-1 (i.e. timeout_cycles cycles in state).
//  - Success input and timeout in the same cycle: success wins.
//  - timeout_cycles=0 disables the timeout. The counter saturates and never wraps.
//  Priority (same cycle):
//  - abort > start > state events.
//  - abort in any state -> IDLE next cycle; retry_count and fail_code keep their values.
//  - start while busy restarts from RESET_GEN with retry_count:=0.
//  Latency: all outputs are registered and reflect the state one cycle after the triggering input.
//  The generator's synchronous state is cleared only via gen_rstn (every RESET_GEN / IDLE / FAIL).
// TESTING
//  - start; captured@+30, ready@+100, no err -> RESET_GEN 16 cyc; locked=1 at +116+256+1; outputs latched.
//  - timeout_cycles=50, captured never -> 4 attempts, retry_count=3, fail=1, fail_code=1.
//  - align_err in VERIFY on attempt 1 only -> retry_count=1, fail_code=3, then locked=1.
//  - locked, then gen_align_err=1 -> fail=1, fail_code=3, gen_rstn=0 next cycle.
//  - abort and start in same cycle during CALIB -> IDLE, gen_rstn=0, busy=0.
//  - gen_ready and timeout on the same cycle in CALIB -> VERIFY, not retry.
//  - rstn low mid-VERIFY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/bsync_align_sequencer_if.sv
// Control, status and generator-facing signals of the BSYNC alignment sequencer.
// master: the sequencer side; slave: register bank / generator side.
interface bsync_align_sequencer_if #(
  parameter int unsigned TIMEOUT_W = 20
);
  logic                 start;
  logic                 abort;
  logic [TIMEOUT_W-1:0] timeout_cycles;

  logic                 gen_rstn;
  logic                 gen_direction;
  logic                 gen_disable_bsync;
  logic                 gen_captured;
  logic                 gen_ready;
  logic                 gen_align_err;
  logic [4:0]           gen_delay;
  logic [15:0]          gen_ratio;

  logic                 busy;
  logic                 locked;
  logic                 fail;
  logic [1:0]           fail_code;
  logic [3:0]           retry_count;
  logic [4:0]           delay_out;
  logic [15:0]          ratio_out;

  modport master (
    input  start, abort, timeout_cycles,
    input  gen_captured, gen_ready, gen_align_err, gen_delay, gen_ratio,
    output gen_rstn, gen_direction, gen_disable_bsync,
    output busy, locked, fail, fail_code, retry_count, delay_out, ratio_out
  );

  modport slave (
    output start, abort, timeout_cycles,
    output gen_captured, gen_ready, gen_align_err, gen_delay, gen_ratio,
    input  gen_rstn, gen_direction, gen_disable_bsync,
    input  busy, locked, fail, fail_code, retry_count, delay_out, ratio_out
  );
endinterface

// File: rtl/bsync_align_sequencer.sv
// Walks one BSYNC generator through reset, capture, calibration and alignment verify,
// retrying a bounded number of times on timeout or misalignment.
module bsync_align_sequencer #(
  parameter int unsigned TIMEOUT_W     = 20,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned VERIFY_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input logic                     clk,
  input logic                     rstn,
  bsync_align_sequencer_if.master bus
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned VerifyW = $clog2(VERIFY_CYCLES + 1);

  localparam logic [SettleW-1:0]   SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [VerifyW-1:0]   VerifyLast = VerifyW'(VERIFY_CYCLES - 1);
  localparam logic [3:0]           RetryMax   = 4'(MAX_RETRIES);
  localparam logic [TIMEOUT_W-1:0] TmoOne     = TIMEOUT_W'(1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StResetGen = 3'd1;
  localparam logic [2:0] StArm      = 3'd2;
  localparam logic [2:0] StCalib    = 3'd3;
  localparam logic [2:0] StVerify   = 3'd4;
  localparam logic [2:0] StLocked   = 3'd5;
  localparam logic [2:0] StFail     = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [SettleW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [VerifyW-1:0]   verify_cnt_q, verify_cnt_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]           retry_q, retry_d;
  logic [1:0]           code_q, code_d;

  logic                 gen_run_q, gen_run_d;
  logic                 gen_disable_q, gen_disable_d;
  logic                 busy_q, busy_d;
  logic                 locked_q, locked_d;
  logic                 fail_q, fail_d;
  logic [4:0]           delay_q;
  logic [15:0]          ratio_q;

  logic                 tmo_hit;
  logic                 restart;
  logic                 retry_req;
  logic [1:0]           retry_code;
  logic                 lock_entry;

  assign tmo_hit = (bus.timeout_cycles != '0) && (tmo_cnt_q == bus.timeout_cycles - TmoOne);
  assign restart = bus.start & ~bus.abort;

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    code_d     = code_q;
    retry_req  = 1'b0;
    retry_code = 2'd0;

    if (bus.abort) begin
      state_d = StIdle;
    end else if (bus.start) begin
      state_d = StResetGen;
      retry_d = 4'd0;
      code_d  = 2'd0;
    end else begin
      case (state_q)
        StResetGen: if (settle_cnt_q == SettleLast) state_d = StArm;
        // Success inputs are tested before the timeout so they win a tie.
        StArm: begin
          if (bus.gen_captured) begin
            state_d = StCalib;
          end else if (tmo_hit) begin
            retry_req  = 1'b1;
            retry_code = 2'd1;
          end
        end
        StCalib: begin
          if (bus.gen_ready) begin
            state_d = StVerify;
          end else if (tmo_hit) begin
            retry_req  = 1'b1;
            retry_code = 2'd2;
          end
        end
        StVerify: begin
          if (bus.gen_align_err) begin
            retry_req  = 1'b1;
            retry_code = 2'd3;
          end else if (verify_cnt_q == VerifyLast) begin
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (bus.gen_align_err) begin
            state_d = StFail;
            code_d  = 2'd3;
          end
        end
        default: ;
      endcase

      if (retry_req) begin
        code_d = retry_code;
        if (retry_q < RetryMax) begin
          retry_d = retry_q + 4'd1;
          state_d = StResetGen;
        end else begin
          state_d = StFail;
        end
      end
    end
  end

  // Every state entry, including a start-triggered re-entry of RESET_GEN, clears the counters.
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    verify_cnt_d = verify_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    if (restart || (state_d != state_q)) begin
      settle_cnt_d = '0;
      verify_cnt_d = '0;
      tmo_cnt_d    = '0;
    end else begin
      if (state_q == StResetGen) settle_cnt_d = settle_cnt_q + SettleW'(1);
      if (state_q == StVerify)   verify_cnt_d = verify_cnt_q + VerifyW'(1);
      if (((state_q == StArm) || (state_q == StCalib)) && (tmo_cnt_q != '1)) begin
        tmo_cnt_d = tmo_cnt_q + TmoOne;
      end
    end
  end

  // Outputs are decoded from the next state so they land in a register with the state.
  always_comb begin
    gen_run_d     = (state_d == StArm) || (state_d == StCalib) ||
                    (state_d == StVerify) || (state_d == StLocked);
    gen_disable_d = !((state_d == StVerify) || (state_d == StLocked));
    busy_d        = (state_d == StResetGen) || (state_d == StArm) ||
                    (state_d == StCalib) || (state_d == StVerify);
    locked_d      = (state_d == StLocked);
    fail_d        = (state_d == StFail);
  end

  assign lock_entry = (state_q == StVerify) && (state_d == StLocked);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      verify_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      retry_q       <= 4'd0;
      code_q        <= 2'd0;
      gen_run_q     <= 1'b0;
      gen_disable_q <= 1'b1;
      busy_q        <= 1'b0;
      locked_q      <= 1'b0;
      fail_q        <= 1'b0;
      delay_q       <= 5'd0;
      ratio_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      verify_cnt_q  <= verify_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      retry_q       <= retry_d;
      code_q        <= code_d;
      gen_run_q     <= gen_run_d;
      gen_disable_q <= gen_disable_d;
      busy_q        <= busy_d;
      locked_q      <= locked_d;
      fail_q        <= fail_d;
      if (lock_entry) begin
        delay_q <= bus.gen_delay;
        ratio_q <= bus.gen_ratio;
      end
    end
  end

  assign bus.gen_rstn          = gen_run_q;
  assign bus.gen_direction     = gen_run_q;
  assign bus.gen_disable_bsync = gen_disable_q;
  assign bus.busy              = busy_q;
  assign bus.locked            = locked_q;
  assign bus.fail              = fail_q;
  assign bus.fail_code         = code_q;
  assign bus.retry_count       = retry_q;
  assign bus.delay_out         = delay_q;
  assign bus.ratio_out         = ratio_q;

endmodule

// File: tb/tb_bsync_align_sequencer.sv
// Scoreboard bench: a behavioural generator responds per attempt, an arithmetic model
// predicts each locked/fail event, and a monitor checks them as they appear.
module tb_bsync_align_sequencer;

  localparam int unsigned TW = 20;
  localparam int SETTLE = 16;
  localparam int VERIFY = 256;
  localparam int MAXR   = 3;
  localparam int NEVER  = 1000000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bsync_align_sequencer_if #(.TIMEOUT_W(TW)) bus ();

  bsync_align_sequencer #(
    .TIMEOUT_W    (TW),
    .SETTLE_CYCLES(SETTLE),
    .VERIFY_CYCLES(VERIFY),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    bit lock;
    int code;
    int retries;
    int off;
    int dly;
    int rat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   scn_id = 0;
  int   cap_t[4];
  int   rdy_t[4];
  int   err_t[4];
  int   dbase = 0;
  int   rbase = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gen_rstn"},    32'(bus.gen_rstn), 0);
    check({tag, "_gen_dir"},     32'(bus.gen_direction), 0);
    check({tag, "_gen_disable"}, 32'(bus.gen_disable_bsync), 1);
    check({tag, "_busy"},        32'(bus.busy), 0);
    check({tag, "_locked"},      32'(bus.locked), 0);
    check({tag, "_fail"},        32'(bus.fail), 0);
    check({tag, "_fail_code"},   32'(bus.fail_code), 0);
    check({tag, "_retry"},       32'(bus.retry_count), 0);
    check({tag, "_delay"},       32'(bus.delay_out), 0);
    check({tag, "_ratio"},       32'(bus.ratio_out), 0);
  endtask

  // Attempt outcome from the generator timing: c = capture, r = ready (cycles after gen_rstn
  // rises), e = cycles into verify before the alignment error.
  task automatic push_expect(input int tmo);
    int   off, retries, code, c, r, e, dur, fcode;
    exp_t x;
    off = 0;
    retries = 0;
    code = 0;
    for (int a = 0; a <= MAXR; a++) begin
      c = cap_t[a];
      r = rdy_t[a];
      e = err_t[a];
      off += SETTLE;
      fcode = 0;
      dur = 0;
      if (tmo != 0 && c >= tmo) begin
        fcode = 1;
        dur = tmo;
      end else if (tmo != 0 && r > c + tmo) begin
        fcode = 2;
        dur = c + 1 + tmo;
      end else if (e < VERIFY) begin
        fcode = 3;
        dur = r + 2 + e;
      end
      if (fcode == 0) begin
        x.lock = 1'b1; x.code = code; x.retries = retries; x.off = off + r + 1 + VERIFY;
        x.dly = (dbase + r + VERIFY) % 32;
        x.rat = (rbase + r + VERIFY) % 65536;
        exp_q.push_back(x);
        if (e < NEVER) begin
          x.lock = 1'b0; x.code = 3; x.retries = retries; x.off = off + r + 2 + e;
          x.dly = 0; x.rat = 0;
          exp_q.push_back(x);
        end
        return;
      end
      if (retries < MAXR) begin
        retries++;
        code = fcode;
        off += dur;
      end else begin
        x.lock = 1'b0; x.code = fcode; x.retries = retries; x.off = off + dur;
        x.dly = 0; x.rat = 0;
        exp_q.push_back(x);
        return;
      end
    end
  endtask

  task automatic set_all(input int c, input int r, input int e);
    for (int a = 0; a < 4; a++) begin
      cap_t[a] = c;
      rdy_t[a] = r;
      err_t[a] = e;
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge (offset 0).
  task automatic start_scn(input int tmo, input bit predict);
    scn_id++;
    bus.timeout_cycles = TW'(tmo);
    if (predict) push_expect(tmo);
    bus.start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d events still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Behavioural generator.
  initial begin : responder
    int   t, a, last_scn;
    logic prev_rstn;
    t = -1;
    a = 0;
    last_scn = -1;
    prev_rstn = 1'b0;
    bus.gen_captured  = 1'b0;
    bus.gen_ready     = 1'b0;
    bus.gen_align_err = 1'b0;
    bus.gen_delay     = 5'd0;
    bus.gen_ratio     = 16'd0;
    forever begin
      @(negedge clk);
      if (scn_id != last_scn) begin
        last_scn = scn_id;
        a = -1;
        prev_rstn = 1'b0;
      end
      if (bus.gen_rstn === 1'b1) begin
        if (!prev_rstn) begin
          t = 0;
          if (a < 3) a++;
        end else begin
          t++;
        end
      end else begin
        t = -1;
      end
      prev_rstn = (bus.gen_rstn === 1'b1);
      if (t >= 0) begin
        bus.gen_captured  = (t >= cap_t[a]);
        bus.gen_ready     = (t >= rdy_t[a]);
        bus.gen_align_err = (bus.gen_disable_bsync === 1'b0) && (t >= rdy_t[a] + 1 + err_t[a]);
        bus.gen_delay     = 5'(dbase + t);
        bus.gen_ratio     = 16'(rbase + t);
      end else begin
        bus.gen_captured  = 1'b0;
        bus.gen_ready     = 1'b0;
        bus.gen_align_err = 1'b0;
        bus.gen_delay     = 5'(dbase);
        bus.gen_ratio     = 16'(rbase);
      end
    end
  end

  initial begin : monitor
    logic prev_l, prev_f;
    exp_t e;
    prev_l = 1'b0;
    prev_f = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && ((bus.locked && !prev_l) || (bus.fail && !prev_f))) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: locked=%0b fail=%0b, expected no event",
                   bus.locked, bus.fail);
        end else begin
          e = exp_q.pop_front();
          check("ev_locked",    32'(bus.locked), 32'(e.lock));
          check("ev_fail",      32'(bus.fail), 32'(!e.lock));
          check("ev_fail_code", 32'(bus.fail_code), 32'(e.code));
          check("ev_retry",     32'(bus.retry_count), 32'(e.retries));
          check("ev_latency",   32'(cyc - start_cyc), 32'(e.off));
          check("ev_busy",      32'(bus.busy), 0);
          if (e.lock) begin
            check("ev_delay_out", 32'(bus.delay_out), 32'(e.dly));
            check("ev_ratio_out", 32'(bus.ratio_out), 32'(e.rat));
          end else begin
            check("ev_gen_rstn", 32'(bus.gen_rstn), 0);
          end
        end
      end
      prev_l = bus.locked;
      prev_f = bus.fail;
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 90000 cycles, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int tmo;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.timeout_cycles = '0;
    set_all(NEVER, NEVER, NEVER);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Plain lock, timeout disabled.
    dbase = 7; rbase = 16'h1234;
    set_all(30, 100, NEVER);
    start_scn(0, 1'b1);
    wait_drain("lock");

    // Capture never arrives: four ARM timeouts.
    set_all(NEVER, NEVER, NEVER);
    start_scn(50, 1'b1);
    wait_drain("arm_timeout");

    // Misalignment on the first attempt only.
    dbase = 3; rbase = 16'hfff0;
    set_all(10, 20, NEVER);
    err_t[0] = 5;
    start_scn(0, 1'b1);
    wait_drain("verify_retry");

    // Lock lost after locking: no retry.
    set_all(10, 20, 300);
    start_scn(0, 1'b1);
    wait_drain("lock_lost");

    // Boundaries: capture exactly at timeout, then capture on the last cycle and ready tied
    // with the CALIB timeout.
    set_all(39, 79, NEVER);
    cap_t[0] = 40;
    rdy_t[0] = 80;
    start_scn(40, 1'b1);
    wait_drain("tmo_ties");

    // start while busy restarts with a cleared retry count.
    set_all(NEVER, NEVER, NEVER);
    start_scn(30, 1'b0);
    repeat (56) @(negedge clk);
    check("busy_retry_before_restart", 32'(bus.retry_count), 1);
    set_all(3, 8, NEVER);
    start_scn(30, 1'b1);
    check("restart_retry", 32'(bus.retry_count), 0);
    check("restart_code",  32'(bus.fail_code), 0);
    check("restart_busy",  32'(bus.busy), 1);
    check("restart_rstn",  32'(bus.gen_rstn), 0);
    wait_drain("restart");

    // abort and start together in CALIB.
    set_all(5, NEVER, NEVER);
    start_scn(0, 1'b0);
    repeat (25) @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_gen_rstn", 32'(bus.gen_rstn), 0);
    check("abort_busy",     32'(bus.busy), 0);
    check("abort_disable",  32'(bus.gen_disable_bsync), 1);
    repeat (20) @(negedge clk);
    check("abort_stays_idle", 32'(bus.busy), 0);

    // abort keeps retry_count and fail_code.
    set_all(NEVER, NEVER, NEVER);
    start_scn(30, 1'b0);
    repeat (60) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_keep_retry", 32'(bus.retry_count), 1);
    check("abort_keep_code",  32'(bus.fail_code), 1);
    check("abort_keep_busy",  32'(bus.busy), 0);

    // Reset in the middle of VERIFY on the second attempt.
    set_all(5, 10, NEVER);
    err_t[0] = 0;
    start_scn(0, 1'b0);
    repeat (100) @(negedge clk);
    check("midverify_retry", 32'(bus.retry_count), 1);
    check("midverify_code",  32'(bus.fail_code), 3);
    check("midverify_dis",   32'(bus.gen_disable_bsync), 0);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_vals("midverify_reset");
    rstn = 1'b1;
    @(negedge clk);

    // Randomised attempt timings.
    for (int k = 0; k < 10; k++) begin
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(15, 70));
      for (int a = 0; a < 4; a++) begin
        cap_t[a] = int'($urandom_range(0, 60));
        if (tmo != 0 && $urandom_range(0, 3) == 0) cap_t[a] = NEVER;
        rdy_t[a] = cap_t[a] + 1 + int'($urandom_range(0, 80));
        if (tmo != 0 && $urandom_range(0, 4) == 0) rdy_t[a] = NEVER;
        err_t[a] = ($urandom_range(0, 1) == 0) ? NEVER : int'($urandom_range(0, 300));
      end
      dbase = int'($urandom_range(0, 31));
      rbase = int'($urandom_range(0, 65535));
      start_scn(tmo, 1'b1);
      wait_drain("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
